// File: rtl/ram_march_tester.sv
// March BIST master for an 8-bit synchronous RAM: W(P), R(P)W(~P), desc R(~P)W(P), R(P).
// Define RAMTEST_STOP_ON_ERR_EN to end the test at the first mismatch.
module ram_march_tester #(
  parameter int               AW      = 8,
  parameter int               DW      = 8,
  parameter logic [DW-1:0]    PATTERN = 8'hA5,
  parameter int               ECW     = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           start,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_rwn,
  input  logic [DW-1:0]  mem_rdata,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [ECW-1:0] err_cnt,
  output logic [1:0]     phase
);

  typedef enum logic [2:0] {
    IDLE, M0_WR, M1, M2, M3, DONE
  } state_t;

  localparam logic [AW-1:0] AMAX = '1;

  state_t         state;
  logic           cmp;
  logic           rwn_q;
  logic [DW-1:0]  exp_d;
  logic           mis;
  logic           stop;
  logic           last;
  logic [ECW-1:0] err_nxt;

  always_comb begin
    exp_d = (state == M2) ? ~PATTERN : PATTERN;
    mis   = cmp && (mem_rdata != exp_d);
    last  = (state == M2) ? (mem_addr == '0)
                          : (mem_addr == AMAX);
    err_nxt = err_cnt;
    if (mis && (err_cnt != '1))
      err_nxt = err_cnt + 1'b1;
  end

`ifdef RAMTEST_STOP_ON_ERR_EN
  // A failing compare must also kill the write issued in the same cycle
  assign stop    = mis;
  assign mem_rwn = rwn_q | mis;
`else
  assign stop    = 1'b0;
  assign mem_rwn = rwn_q;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cmp       <= 1'b0;
      rwn_q     <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      phase     <= 2'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= M0_WR;
            cmp       <= 1'b0;
            rwn_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= PATTERN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            phase     <= 2'd0;
          end
        end
        M0_WR: begin
          if (mem_addr == AMAX) begin
            state    <= M1;
            rwn_q    <= 1'b1;
            mem_addr <= '0;
            phase    <= 2'd1;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        M1, M2, M3: begin
          if (!cmp) begin
            cmp <= 1'b1;
            if (state != M3) begin
              rwn_q     <= 1'b0;
              mem_wdata <= (state == M1) ? ~PATTERN : PATTERN;
            end
          end else begin
            cmp     <= 1'b0;
            rwn_q   <= 1'b1;
            err_cnt <= err_nxt;
            if (stop) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b0;
            end else if (last) begin
              unique case (state)
                M1: begin
                  state    <= M2;
                  mem_addr <= AMAX;
                  phase    <= 2'd2;
                end
                M2: begin
                  state    <= M3;
                  mem_addr <= '0;
                  phase    <= 2'd3;
                end
                default: begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
                end
              endcase
            end else if (state == M2) begin
              mem_addr <= mem_addr - 1'b1;
            end else begin
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: behavioural RAM with injectable faults,
// table of full runs plus hand-written reset sequences.
module tb_ram_march_tester;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rwn;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [1:0]  phase;

  always #5 Clk = ~Clk;

  ram_march_tester dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rwn   (mem_rwn),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .phase     (phase)
  );

  // fault: 0 ideal, 1 addr 3C bit0 stuck-at-1, 2 addr bit7 ignored
  logic [7:0] ram [256];
  int fault  = 0;
  int writes = 0;

  always @(posedge Clk) begin : ram_model
    logic [7:0] ix;
    ix = (fault == 2) ? {1'b0, mem_addr[6:0]} : mem_addr;
    if (!mem_rwn) begin
      ram[ix] <= mem_wdata;
      writes  <= writes + 1;
    end
    mem_rdata <= ram[ix] |
      ((fault == 1 && mem_addr == 8'h3C) ? 8'h01 : 8'h00);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  typedef struct {
    int mode;
    int restart;
    int cyc;
    int err;
    int pss;
    int ph;
    int addr;
    int wr;
  } vec_t;

  vec_t vt [5];

  task automatic run_vec(input vec_t t);
    int cyc;
    int w0;
    fault = t.mode;
    w0 = writes;
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (cyc == 1) begin
        chk("first_busy", 32'(busy), 1);
        chk("first_rwn", 32'(mem_rwn), 0);
        chk("first_addr", 32'(mem_addr), 0);
        chk("first_wdata", 32'(mem_wdata), 32'hA5);
        chk("first_err", 32'(err_cnt), 0);
      end
      if (cyc == 257)
        chk("m1_entry", {phase, mem_rwn, mem_addr},
            {2'd1, 1'b1, 8'h00});
      if (cyc == 769)
        chk("m2_entry", {phase, mem_rwn, mem_addr},
            {2'd2, 1'b1, 8'hFF});
      if (cyc == 1281)
        chk("m3_entry", {phase, mem_rwn, mem_addr},
            {2'd3, 1'b1, 8'h00});
      start = (cyc == t.restart);
      @(posedge Clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("busy_cycles", cyc - 1, t.cyc);
    chk("end_flags", {busy, done, mem_rwn}, 3'b011);
    chk("end_err", 32'(err_cnt), t.err);
    chk("end_pass", 32'(pass), t.pss);
    chk("end_phase", 32'(phase), t.ph);
    chk("end_addr", 32'(mem_addr), t.addr);
    chk("write_count", writes - w0, t.wr);
    repeat (5) @(posedge Clk);
    #1;
    chk("idle_no_write", writes - w0, t.wr);
    chk("idle_done", {busy, done}, 2'b01);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst   = 1'b1;
    start = 1'b0;
`ifdef RAMTEST_STOP_ON_ERR_EN
    vt[0] = '{0, 0, 1792, 0, 1, 3, 255, 768};
    vt[1] = '{1, 0, 1160, 1, 0, 2, 60, 707};
    vt[2] = '{2, 0, 514, 1, 0, 1, 128, 384};
    vt[3] = '{0, 100, 1792, 0, 1, 3, 255, 768};
    vt[4] = '{2, 100, 514, 1, 0, 1, 128, 384};
`else
    vt[0] = '{0, 0, 1792, 0, 1, 3, 255, 768};
    vt[1] = '{1, 0, 1792, 1, 0, 3, 255, 768};
    vt[2] = '{2, 0, 1792, 256, 0, 3, 255, 768};
    vt[3] = '{0, 100, 1792, 0, 1, 3, 255, 768};
    vt[4] = '{2, 100, 1792, 256, 0, 3, 255, 768};
`endif
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_bus", {mem_addr, mem_wdata, mem_rwn},
        {8'h00, 8'h00, 1'b1});
    chk("rst_stat", {busy, done, pass, err_cnt, phase}, 21'd0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("idle_stay", {busy, done, mem_rwn}, 3'b001);

    for (int i = 0; i < 5; i++)
      run_vec(vt[i]);

    // reset mid-test lands between edges and must act at once
    fault = 0;
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (499) @(posedge Clk);
    #1;
    chk("mid_busy", 32'(busy), 1);
    #1;
    Rst = 1'b1;
    #1;
    chk("async_bus", {mem_addr, mem_wdata, mem_rwn},
        {8'h00, 8'h00, 1'b1});
    chk("async_stat", {busy, done, pass, err_cnt, phase}, 21'd0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("post_rst_idle", {busy, done, mem_rwn}, 3'b001);
    run_vec(vt[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
